// File: rtl/ext_com_pkg.sv
// ext_com_pkg: shared types and constants for the external-communication
// UART link toward the companion FPGA.
package ext_com_pkg;

  localparam int UART_WIDTH_DEF = 8;
  localparam logic [7:0] UART_ACK_DEF = 8'b11001100;

  typedef enum logic [3:0] {
    IDLE,
    START,
    DATA,
    STOP,
    ACK_WAIT,
    ACK_RX,
    RETRY,
    DONE,
    FAIL
  } uart_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_ack_transmitter_if.sv
// uart_ack_transmitter_if: byte request/status bundle between the
// ext_com controller (master) and the acknowledged UART sender (slave).
interface uart_ack_transmitter_if #(
  parameter int UART_WIDTH = 8
);
  logic                  send_req;
  logic [UART_WIDTH-1:0] send_data;
  logic                  busy;
  logic                  done;
  logic                  fail;
  logic [2:0]            attempt;

  modport master (
    output send_req, send_data,
    input  busy, done, fail, attempt
  );

  modport slave (
    input  send_req, send_data,
    output busy, done, fail, attempt
  );
endinterface

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: self-reloading bit-period down-counter with a
// full-period tick and a mid-period half tick.
module uart_baud_counter #(
  parameter int CPB = 217
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic tick_o,
  output logic half_o
);

  localparam int CW = ($clog2(CPB) > 0) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] TOP = CW'(CPB - 1);
  localparam logic [CW-1:0] MID = CW'(CPB / 2);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= TOP;
    end else if (en_i) begin
      cnt_q <= (cnt_q == '0) ? TOP : cnt_q - CW'(1);
    end
  end

  assign tick_o = en_i && (cnt_q == '0);
  assign half_o = en_i && (cnt_q == MID);

endmodule

// File: rtl/uart_ack_transmitter.sv
// uart_ack_transmitter: sends one byte over UART and waits for an
// acknowledge byte on rx, retransmitting on timeout or a bad reply.
module uart_ack_transmitter
  import ext_com_pkg::*;
#(
  parameter int CLK_FREQ              = 50_000_000,
  parameter int UART_BAUD_RATE        = 230400,
  parameter int UART_WIDTH            = UART_WIDTH_DEF,
  parameter int UART_RETRANSMIT_COUNT = 5,
  parameter logic [UART_WIDTH-1:0] UART_ACK = UART_WIDTH'(UART_ACK_DEF),
  parameter int ACK_TIMEOUT_BITS      = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_ack_transmitter_if.slave ctrl,
  output logic                  tx,
  input  logic                  rx
);

  localparam int CPB    = clks_per_bit(CLK_FREQ, UART_BAUD_RATE);
  localparam int TO_LIM = ACK_TIMEOUT_BITS * CPB;
  localparam int TOW    = $clog2(TO_LIM + 1);
  localparam int RW     = $clog2(UART_WIDTH + 2);
  localparam logic [2:0] MAX_ATT = 3'(UART_RETRANSMIT_COUNT + 1);

  if (UART_RETRANSMIT_COUNT > 6) begin : g_bad_retx
    $error("UART_RETRANSMIT_COUNT must be <= 6");
  end

  uart_state_e           state_q;
  logic [UART_WIDTH-1:0] data_q;
  logic [UART_WIDTH-1:0] sh_q;
  logic [RW-1:0]         idx_q;
  logic [TOW-1:0]        to_q;
  logic [2:0]            att_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  fail_q;
  logic                  rx_meta_q;
  logic                  rx_sync_q;
  logic                  rx_prev_q;

  logic tick;
  logic half;
  logic fall;
  logic bc_load;
  logic bc_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign fall  = rx_prev_q & ~rx_sync_q;
  assign bc_en = state_q inside {START, DATA, STOP, ACK_RX};
  assign bc_load = (state_q == IDLE && ctrl.send_req)
                || (state_q == ACK_WAIT && fall)
                || (state_q == RETRY);

  uart_baud_counter #(
    .CPB (CPB)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .load_i (bc_load),
    .en_i   (bc_en),
    .tick_o (tick),
    .half_o (half)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
      to_q    <= '0;
      att_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      fail_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ctrl.send_req) begin
            data_q  <= ctrl.send_data;
            att_q   <= 3'd1;
            busy_q  <= 1'b1;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_q    <= data_q[0];
            sh_q    <= data_q >> 1;
            idx_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (idx_q == RW'(UART_WIDTH - 1)) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tx_q  <= sh_q[0];
              sh_q  <= sh_q >> 1;
              idx_q <= idx_q + RW'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            to_q    <= '0;
            state_q <= ACK_WAIT;
          end
        end
        ACK_WAIT: begin
          to_q <= to_q + TOW'(1);
          if (fall) begin
            idx_q   <= '0;
            state_q <= ACK_RX;
          end else if (to_q == TOW'(TO_LIM - 1)) begin
            state_q <= RETRY;
          end
        end
        ACK_RX: begin
          // the timeout is frozen here so a rejected glitch resumes it
          if (half) begin
            if (idx_q == '0) begin
              if (rx_sync_q) begin
                state_q <= ACK_WAIT;
              end else begin
                idx_q <= RW'(1);
              end
            end else if (idx_q == RW'(UART_WIDTH + 1)) begin
              if (sh_q == UART_ACK && rx_sync_q) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= DONE;
              end else begin
                state_q <= RETRY;
              end
            end else begin
              sh_q  <= {rx_sync_q, sh_q[UART_WIDTH-1:1]};
              idx_q <= idx_q + RW'(1);
            end
          end
        end
        RETRY: begin
          if (att_q == MAX_ATT) begin
            fail_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FAIL;
          end else begin
            att_q   <= att_q + 3'd1;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        DONE:    state_q <= IDLE;
        FAIL:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx           = tx_q;
  assign ctrl.busy    = busy_q;
  assign ctrl.done    = done_q;
  assign ctrl.fail    = fail_q;
  assign ctrl.attempt = att_q;

endmodule

// File: tb/tb_uart_ack_transmitter.sv
// tb_uart_ack_transmitter: scoreboard bench decoding tx frames and
// playing the external device on rx.
module tb_uart_ack_transmitter;

  localparam int CPB = 8;
  localparam int TO  = 40 * CPB;
  localparam int FRM = 10 * CPB;

  typedef struct packed {
    logic       is_done;
    logic [2:0] att;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx;

  uart_ack_transmitter_if #(.UART_WIDTH(8)) ctrl ();

  uart_ack_transmitter #(
    .CLK_FREQ       (1_000_000),
    .UART_BAUD_RATE (125_000)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (ctrl),
    .tx   (tx),
    .rx   (rx)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int frames = 0;
  int n_res = 0;
  int fst[$];
  logic [7:0] exp_q[$];
  res_t res_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  initial begin : tx_mon
    logic txp;
    logic sb;
    logic pb;
    logic ab;
    logic [7:0] b;
    logic [7:0] e;
    int t0;
    txp = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && txp && !tx) begin
        t0 = cyc;
        ab = 1'b0;
        repeat (CPB / 2 - 1) begin
          @(negedge clk);
          if (rst) ab = 1'b1;
        end
        sb = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
          end
          b[i] = tx;
        end
        repeat (CPB) begin
          @(negedge clk);
          if (rst) ab = 1'b1;
        end
        pb = tx;
        if (!ab) begin
          chk("tx_start_bit", sb, 1'b0);
          chk("tx_stop_bit", pb, 1'b1);
          chk("frame_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("tx_byte", b, e);
          end
          fst.push_back(t0);
          frames++;
        end
      end
      txp = tx;
    end
  end

  initial begin : res_mon
    res_t e;
    forever begin
      @(negedge clk);
      if (ctrl.done || ctrl.fail) begin
        n_res++;
        chk("done_fail_excl", ctrl.done & ctrl.fail, 0);
        chk("busy_at_end", ctrl.busy, 0);
        chk("result_expected", res_q.size() > 0, 1);
        if (res_q.size() > 0) begin
          e = res_q.pop_front();
          chk("done_vs_fail", ctrl.done, e.is_done);
          chk("attempt", ctrl.attempt, e.att);
          @(negedge clk);
          chk("pulse_1cyc", ctrl.done | ctrl.fail, 0);
          chk("attempt_hold", ctrl.attempt, e.att);
        end
      end
    end
  end

  task automatic req(input logic [7:0] b);
    @(negedge clk);
    ctrl.send_req  = 1'b1;
    ctrl.send_data = b;
    @(negedge clk);
    ctrl.send_req  = 1'b0;
    ctrl.send_data = 8'h00;
  endtask

  task automatic send_rx(input logic [7:0] b);
    repeat (2 * CPB) @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (frames < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (frames < n) chk("frame_wait", frames, n);
  endtask

  task automatic wait_res(input int n, input int budget);
    int k = 0;
    while (n_res < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (n_res < n) chk("result_wait", n_res, n);
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_txn(input logic [7:0] b, input int n,
                            input logic dn, input logic [2:0] att);
    for (int i = 0; i < n; i++) exp_q.push_back(b);
    res_q.push_back('{is_done: dn, att: att});
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int f0;
    int r0;
    int g;
    ctrl.send_req  = 1'b0;
    ctrl.send_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", ctrl.busy, 0);
    chk("rst_done", ctrl.done, 0);
    chk("rst_fail", ctrl.fail, 0);
    chk("rst_attempt", ctrl.attempt, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // happy path
    f0 = frames;
    expect_txn(8'h2A, 1, 1'b1, 3'd1);
    req(8'h2A);
    chk("t1_busy", ctrl.busy, 1);
    chk("t1_attempt", ctrl.attempt, 1);
    wait_frames(f0 + 1, 2 * FRM);
    send_rx(8'hCC);
    wait_res(1, 4 * FRM);
    chk("t1_busy_after", ctrl.busy, 0);

    // timeout: six identical frames then fail
    f0 = frames;
    expect_txn(8'h3B, 6, 1'b0, 3'd6);
    req(8'h3B);
    wait_res(2, 7 * (FRM + TO) + 200);
    chk("t2_frames", frames - f0, 6);
    for (int i = f0 + 1; i < f0 + 6 && i < fst.size(); i++) begin
      g = fst[i] - fst[i-1];
      chk("t2_gap", (g >= FRM + TO) && (g <= FRM + TO + 4), 1);
    end

    // wrong ack then correct ack
    f0 = frames;
    expect_txn(8'h5A, 2, 1'b1, 3'd2);
    req(8'h5A);
    wait_frames(f0 + 1, 2 * FRM);
    send_rx(8'h33);
    wait_frames(f0 + 2, 3 * FRM);
    send_rx(8'hCC);
    wait_res(3, 4 * FRM);
    repeat (2 * FRM) @(negedge clk);
    chk("t3_frames", frames - f0, 2);

    // glitch on rx is rejected
    f0 = frames;
    r0 = n_res;
    expect_txn(8'hC3, 1, 1'b1, 3'd1);
    req(8'hC3);
    wait_frames(f0 + 1, 2 * FRM);
    repeat (2 * CPB) @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (10 * CPB) @(negedge clk);
    chk("t4_still_busy", ctrl.busy, 1);
    chk("t4_no_result", n_res, r0);
    send_rx(8'hCC);
    wait_res(r0 + 1, 4 * FRM);
    repeat (2 * FRM) @(negedge clk);
    chk("t4_frames", frames - f0, 1);

    // send_req while busy is ignored
    f0 = frames;
    r0 = n_res;
    expect_txn(8'h2F, 1, 1'b1, 3'd1);
    req(8'h2F);
    repeat (3 * CPB) @(negedge clk);
    ctrl.send_req  = 1'b1;
    ctrl.send_data = 8'hFF;
    @(negedge clk);
    ctrl.send_req  = 1'b0;
    wait_frames(f0 + 1, 2 * FRM);
    send_rx(8'hCC);
    wait_res(r0 + 1, 4 * FRM);
    repeat (2 * FRM) @(negedge clk);
    chk("t5_frames", frames - f0, 1);

    // reset in the middle of data bit 4
    f0 = frames;
    r0 = n_res;
    req(8'h45);
    repeat (5 * CPB + CPB / 2 - 1) @(negedge clk);
    chk("t6_pre_rst_tx", tx, 0);
    rst = 1'b1;
    #1;
    chk("t6_rst_tx", tx, 1);
    chk("t6_rst_busy", ctrl.busy, 0);
    chk("t6_rst_attempt", ctrl.attempt, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    chk("t6_no_result", n_res, r0);
    chk("t6_no_frame", frames, f0);
    expect_txn(8'h45, 1, 1'b1, 3'd1);
    req(8'h45);
    chk("t6_attempt", ctrl.attempt, 1);
    wait_frames(f0 + 1, 2 * FRM);
    send_rx(8'hCC);
    wait_res(r0 + 1, 4 * FRM);

    repeat (4 * CPB) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("res_q_empty", res_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
